// File: rtl/timer_tick_pkg.sv
// Shared definitions for the timer_tick CSR map and the tick scheduler FSM.
package timer_tick_pkg;

  // CSR addresses of the timer_tick register file
  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_COUNTER = 2'd2;

  // CONTROL register bit positions
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_IE_BIT   = 2;
  localparam int CTRL_IP_BIT   = 3;

  // CONTROL mode field encodings
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // CONTROL values written by the scheduler
  localparam logic [31:0] CTRL_DIS = 32'h0000_0000;  // disabled, IP cleared
  localparam logic [31:0] CTRL_ARM = 32'h0000_0006;  // ie=1, one-shot

  // Scheduler FSM states
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_W_DIS  = 4'd1;
  localparam state_t ST_W_PER  = 4'd2;
  localparam state_t ST_W_CNT  = 4'd3;
  localparam state_t ST_W_ARM  = 4'd4;
  localparam state_t ST_SETTLE = 4'd5;
  localparam state_t ST_WAIT   = 4'd6;
  localparam state_t ST_RD     = 4'd7;
  localparam state_t ST_CLR    = 4'd8;
  localparam state_t ST_FIN    = 4'd9;

endpackage

// File: rtl/timer_tick_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from (last winner + 1), one-hot grant.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic             en_i,
  input  logic             accept_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                             input logic [PW:0]   off);
    logic [PW:0] s;
    s = {1'b0, base} + off;
    if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
    return s[PW-1:0];
  endfunction

  // Pick the first active request after the last winner, wrapping around
  always_comb begin
    gnt_o = '0;
    win   = ptr_r;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = wrap_idx(ptr_r, (PW+1)'(i));
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (en_i && found) gnt_o[win] = 1'b1;
  end

  // Remember the winner once the grant is taken
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) ptr_r <= '0;
    else if (accept_i && found) ptr_r <= win;
  end

endmodule

// File: rtl/timer_tick_sched.sv
// Shares one timer_tick among N_REQ one-shot timeout requesters.
module timer_tick_sched
  import timer_tick_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rstb_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [32*N_REQ-1:0] period_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    done_o,
  output logic [N_REQ-1:0]    abort_o,
  output logic [31:0]         elapsed_o,
  output logic                busy_o,
  output logic                tmr_re_o,
  output logic                tmr_we_o,
  output logic [1:0]          tmr_addr_o,
  output logic [31:0]         tmr_data_o,
  input  logic [31:0]         tmr_data_i,
  input  logic                tmr_intr_i
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_t             state_r;
  state_t             ret_r;
  logic [CW-1:0]      settle_cnt_r;
  logic [N_REQ-1:0]   gnt_r;
  logic [N_REQ-1:0]   arb_gnt;
  logic [31:0]        period_sel;
  logic [31:0]        period_r;
  logic [31:0]        elapsed_r;
  logic               cancel_r;
  logic               abort_r;
  logic               arb_en;
  logic               arb_accept;
  logic               req_granted;

  // The timer cannot express a one-shot shorter than 2 ticks
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

  assign arb_en      = (state_r == ST_IDLE);
  assign arb_accept  = arb_en && (|req_i);
  assign req_granted = |(req_i & gnt_r);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i    (clk_i),
    .rstb_i   (rstb_i),
    .en_i     (arb_en),
    .accept_i (arb_accept),
    .req_i    (req_i),
    .gnt_o    (arb_gnt)
  );

  // Select the period of the requester the arbiter is about to grant
  always_comb begin
    period_sel = '0;
    for (int k = 0; k < N_REQ; k++)
      if (arb_gnt[k]) period_sel = period_i[32*k +: 32];
  end

  // Main sequencer: grant, program, wait, read/clear, report
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_r      <= ST_IDLE;
      ret_r        <= ST_IDLE;
      settle_cnt_r <= '0;
      gnt_r        <= '0;
      abort_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: if (arb_accept) begin
          gnt_r   <= arb_gnt;
          abort_r <= 1'b0;
          state_r <= ST_W_DIS;
        end
        ST_W_DIS: begin state_r <= ST_SETTLE; ret_r <= ST_W_PER; settle_cnt_r <= '0; end
        ST_W_PER: begin state_r <= ST_SETTLE; ret_r <= ST_W_CNT; settle_cnt_r <= '0; end
        ST_W_CNT: begin state_r <= ST_SETTLE; ret_r <= ST_W_ARM; settle_cnt_r <= '0; end
        ST_W_ARM: begin state_r <= ST_SETTLE; ret_r <= ST_WAIT;  settle_cnt_r <= '0; end
        ST_CLR:   begin state_r <= ST_SETTLE; ret_r <= ST_FIN;   settle_cnt_r <= '0; end
        ST_SETTLE: begin
          if (settle_cnt_r == CW'(SETTLE_CYC - 1)) state_r <= ret_r;
          else settle_cnt_r <= settle_cnt_r + 1'b1;
        end
        ST_WAIT: begin
          // Interrupt takes priority over a pending cancel
          if (tmr_intr_i) state_r <= ST_CLR;
          else if (cancel_r) begin
            state_r <= ST_RD;
            abort_r <= 1'b1;
          end
        end
        ST_RD:   state_r <= ST_CLR;
        ST_FIN: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Cancel is sticky for the whole service and only acted upon in WAIT
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) cancel_r <= 1'b0;
    else if (state_r == ST_IDLE) cancel_r <= 1'b0;
    else if (!req_granted) cancel_r <= 1'b1;
  end

  // Period latch at grant and elapsed capture on interrupt or counter read
  always_ff @(posedge clk_i) begin
    if (arb_accept) period_r <= clamp_period(period_sel);
    if (state_r == ST_WAIT && tmr_intr_i) elapsed_r <= period_r;
    else if (state_r == ST_RD) elapsed_r <= tmr_data_i;
  end

  // Requester-side outputs decoded from state, zero outside their window
  always_comb begin
    busy_o    = (state_r != ST_IDLE);
    gnt_o     = (busy_o && state_r != ST_FIN) ? gnt_r : '0;
    done_o    = (state_r == ST_FIN && !abort_r) ? gnt_r : '0;
    abort_o   = (state_r == ST_FIN &&  abort_r) ? gnt_r : '0;
    elapsed_o = (state_r == ST_FIN) ? elapsed_r : '0;
  end

  // Timer CSR strobes; address and data are zero when no strobe is active
  always_comb begin
    tmr_re_o   = 1'b0;
    tmr_we_o   = 1'b0;
    tmr_addr_o = '0;
    tmr_data_o = '0;
    case (state_r)
      ST_W_DIS: begin tmr_we_o = 1'b1; tmr_addr_o = ADDR_CONTROL; tmr_data_o = CTRL_DIS; end
      ST_W_PER: begin tmr_we_o = 1'b1; tmr_addr_o = ADDR_PERIOD;  tmr_data_o = period_r; end
      ST_W_CNT: begin tmr_we_o = 1'b1; tmr_addr_o = ADDR_COUNTER; tmr_data_o = 32'd1;    end
      ST_W_ARM: begin tmr_we_o = 1'b1; tmr_addr_o = ADDR_CONTROL; tmr_data_o = CTRL_ARM; end
      ST_CLR:   begin tmr_we_o = 1'b1; tmr_addr_o = ADDR_CONTROL; tmr_data_o = CTRL_DIS; end
      ST_RD:    begin tmr_re_o = 1'b1; tmr_addr_o = ADDR_COUNTER; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_tick_sched.sv
// Scoreboard bench for timer_tick_sched with a behavioural timer_tick model.
module tb_timer_tick_sched;

  localparam int N = 4;
  localparam int S = 16;

  logic            clk = 1'b0;
  logic            rstb = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] period = '0;
  logic [N-1:0]    gnt, done, abort;
  logic [31:0]     elapsed;
  logic            busy, tmr_re, tmr_we;
  logic [1:0]      tmr_addr;
  logic [31:0]     tmr_wdata, tmr_rdata;
  logic            tmr_intr;

  timer_tick_sched #(.N_REQ(N), .SETTLE_CYC(S)) dut (
    .clk_i(clk), .rstb_i(rstb), .req_i(req), .period_i(period),
    .gnt_o(gnt), .done_o(done), .abort_o(abort), .elapsed_o(elapsed),
    .busy_o(busy), .tmr_re_o(tmr_re), .tmr_we_o(tmr_we), .tmr_addr_o(tmr_addr),
    .tmr_data_o(tmr_wdata), .tmr_data_i(tmr_rdata), .tmr_intr_i(tmr_intr)
  );

  always #5 clk = ~clk;

  // Timer model: one tick per clk, one-shot raises IP when count reaches period
  logic [31:0] m_ctrl, m_per, m_cnt;
  logic        m_ip;
  logic        force_intr = 1'b0;
  assign tmr_intr  = (m_ip & m_ctrl[2]) | force_intr;
  assign tmr_rdata = (tmr_re && tmr_addr == 2'd2) ? m_cnt : 32'h0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_ctrl <= '0; m_per <= '0; m_cnt <= '0; m_ip <= 1'b0;
    end else if (tmr_we) begin
      case (tmr_addr)
        2'd0: begin m_ctrl <= tmr_wdata; m_ip <= tmr_wdata[3]; end
        2'd1: m_per <= tmr_wdata;
        2'd2: m_cnt <= tmr_wdata;
        default: ;
      endcase
    end else if (m_ctrl[1:0] != 2'b00 && !m_ip) begin
      if (m_cnt >= m_per) m_ip <= 1'b1;
      else m_cnt <= m_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit ab; int idx; int unsigned el; int unsigned tol; } comp_t;
  wr_t   wr_q[$];
  comp_t comp_q[$];
  int    gnt_q[$];

  int cyc = 0, last_wr = -1, wr_seen = 0, rd_seen = 0, gnt_seen = 0, comp_seen = 0;
  logic [N-1:0] prev_gnt = '0;

  // Expected bus traffic, grant and completion of one service
  task automatic push_txn(input int idx, input int unsigned per, input bit ab,
                          input int unsigned el, input int unsigned tol);
    int unsigned p;
    p = (per < 2) ? 2 : per;
    wr_q.push_back('{2'd0, 32'h0});
    wr_q.push_back('{2'd1, p});
    wr_q.push_back('{2'd2, 32'h1});
    wr_q.push_back('{2'd0, 32'h6});
    wr_q.push_back('{2'd0, 32'h0});
    gnt_q.push_back(idx);
    comp_q.push_back('{ab, idx, ab ? el : p, tol});
  endtask

  // Monitor: compares DUT activity against the scoreboard queues
  always @(negedge clk) begin
    wr_t   w;
    comp_t c;
    int    g;
    int unsigned d;
    if (!rstb) begin
      last_wr  = -1;
      prev_gnt = '0;
    end else begin
      cyc++;
      if (tmr_we) begin
        wr_seen++;
        if (wr_q.size() == 0) chk("wr_unexpected", {tmr_addr, tmr_wdata}, 64'h0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", tmr_addr, w.addr);
          chk("wr_data", tmr_wdata, w.data);
        end
        if (last_wr >= 0) chk("wr_gap_ok", (cyc - last_wr) >= S + 1, 1);
        last_wr = cyc;
      end
      if (tmr_re) begin
        rd_seen++;
        chk("rd_addr", tmr_addr, 2);
      end
      if (!tmr_we && !tmr_re) chk("bus_idle_zero", {tmr_addr, tmr_wdata}, 0);
      if (tmr_we && tmr_re) chk("we_re_both", 1, 0);
      if (gnt != 0 && prev_gnt == 0) begin
        gnt_seen++;
        chk("gnt_onehot", $onehot(gnt), 1);
        if (gnt_q.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          g = gnt_q.pop_front();
          chk("gnt_idx", gnt, 64'(1) << g);
        end
      end
      if (gnt != 0 && prev_gnt != 0) chk("gnt_stable", gnt, prev_gnt);
      if (done != 0 || abort != 0) begin
        comp_seen++;
        chk("gnt_low_at_fin", gnt, 0);
        chk("busy_at_fin", busy, 1);
        if (comp_q.size() == 0) chk("comp_unexpected", {done, abort}, 0);
        else begin
          c = comp_q.pop_front();
          chk("comp_is_abort", abort != 0, c.ab);
          chk("comp_vector", done | abort, 64'(1) << c.idx);
          if (c.tol == 0) chk("elapsed", elapsed, c.el);
          else begin
            d = (elapsed > c.el) ? elapsed - c.el : c.el - elapsed;
            chk($sformatf("elapsed_near_%0d_got_%0d", c.el, elapsed), d <= c.tol, 1);
          end
        end
      end
      if (done == 0 && abort == 0) chk("elapsed_zero_idle", elapsed, 0);
      prev_gnt = gnt;
    end
  end

  task automatic wait_cnt(input string tag, ref int cnt, input int target, input int budget);
    int i;
    i = 0;
    while (cnt < target && i < budget) begin @(negedge clk); i++; end
    if (cnt < target) chk({"timeout_", tag}, cnt, target);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done_abort"}, {done, abort}, 0);
    chk({tag, "_elapsed"}, elapsed, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bus"}, {tmr_re, tmr_we, tmr_addr, tmr_wdata}, 0);
  endtask

  initial begin
    int base, i, w0;
    // reset state
    #12 check_all_zero("reset");
    @(negedge clk) rstb = 1'b1;
    repeat (3) @(negedge clk);

    // single request, period 100
    period[0*32 +: 32] = 100;
    push_txn(0, 100, 0, 0, 0);
    req[0] = 1'b1;
    wait_cnt("t1_done", comp_seen, 1, 3000);
    req = '0;
    repeat (4) @(negedge clk);

    // round robin: pointer is at 0, so rotation starts at 1
    period = {32'd40, 32'd30, 32'd20, 32'd10};
    push_txn(1, 20, 0, 0, 0);
    push_txn(2, 30, 0, 0, 0);
    push_txn(3, 40, 0, 0, 0);
    push_txn(0, 10, 0, 0, 0);
    push_txn(1, 20, 0, 0, 0);
    base = gnt_seen;
    req = '1;
    wait_cnt("t2_grants", gnt_seen, base + 5, 3000);
    req = 4'b0010;
    wait_cnt("t2_done", comp_seen, 6, 1000);
    req = '0;
    repeat (4) @(negedge clk);

    // cancel in WAIT after 200 ticks
    period[2*32 +: 32] = 1000;
    push_txn(2, 1000, 1, 200, 2);
    base = rd_seen;
    req[2] = 1'b1;
    i = 0;
    while (m_cnt != 200 && i < 3000) begin @(negedge clk); i++; end
    if (m_cnt != 200) chk("timeout_t3_cnt", m_cnt, 200);
    req[2] = 1'b0;
    wait_cnt("t3_done", comp_seen, 7, 500);
    chk("t3_one_read", rd_seen, base + 1);
    repeat (4) @(negedge clk);

    // cancel during PERIOD settle: programming completes, then read and abort
    period[1*32 +: 32] = 500;
    push_txn(1, 500, 1, 18, 2);
    w0 = wr_seen;
    req[1] = 1'b1;
    wait_cnt("t4_wper", wr_seen, w0 + 2, 500);
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    wait_cnt("t4_done", comp_seen, 8, 500);
    chk("t4_one_read", rd_seen, base + 2);
    repeat (4) @(negedge clk);

    // period 0 is clamped to 2
    period[0*32 +: 32] = 0;
    push_txn(0, 0, 0, 0, 0);
    req[0] = 1'b1;
    wait_cnt("t5a_done", comp_seen, 9, 500);
    req = '0;
    repeat (4) @(negedge clk);

    // interrupt and pending cancel in the same WAIT cycle: done wins
    period[2*32 +: 32] = 5000;
    push_txn(2, 5000, 0, 0, 0);
    w0 = wr_seen;
    req[2] = 1'b1;
    wait_cnt("t5b_arm", wr_seen, w0 + 4, 500);
    repeat (S + 3) @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk) force_intr = 1'b1;
    @(negedge clk) force_intr = 1'b0;
    wait_cnt("t5b_done", comp_seen, 10, 200);
    chk("t5b_no_read", rd_seen, base + 2);
    repeat (4) @(negedge clk);

    // spurious interrupt in IDLE
    w0 = wr_seen;
    force_intr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spurious_busy", busy, 0);
    end
    force_intr = 1'b0;
    repeat (3) @(negedge clk);
    chk("spurious_no_write", wr_seen, w0);

    // reset during WAIT
    period[1*32 +: 32] = 5000;
    push_txn(1, 5000, 0, 0, 0);
    w0 = wr_seen;
    req[1] = 1'b1;
    wait_cnt("t6_arm", wr_seen, w0 + 4, 500);
    repeat (S + 3) @(negedge clk);
    #2 rstb = 1'b0;
    #1 check_all_zero("async_rst");
    wr_q.delete(); comp_q.delete(); gnt_q.delete();
    req = '0;
    @(negedge clk) rstb = 1'b1;
    repeat (2) @(negedge clk);

    // after reset the pointer search starts at 1: 1 before 3
    period[1*32 +: 32] = 7;
    period[3*32 +: 32] = 3;
    push_txn(1, 7, 0, 0, 0);
    push_txn(3, 3, 0, 0, 0);
    base = comp_seen;
    req = 4'b1010;
    wait_cnt("t6_first", comp_seen, base + 1, 500);
    req[1] = 1'b0;
    wait_cnt("t6_second", comp_seen, base + 2, 500);
    req = '0;
    repeat (5) @(negedge clk);

    chk("wr_q_left", wr_q.size(), 0);
    chk("comp_q_left", comp_q.size(), 0);
    chk("gnt_q_left", gnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
